cl_ocl_axil_master: RTL
=======================

# cl_ocl_axil_master

AXI4-Lite initiator that turns single-word commands from a simple valid/ready request port into single-beat AXI-Lite write or read transactions, and returns each response on a valid/ready response port. It sits in the CL on `clk_main_a0`. It drives an AXI-Lite register target, the counterpart of the OCL BAR0 register slave. It keeps one transaction outstanding at a time and counts completed writes and reads.

## Interface
- `TIMEOUT_CYCLES`, 1024 — cycles allowed in the B/R wait phase before abort (used only with the timeout build option).
- `TIMEOUT_W`, 16 — width of the watchdog counter; must satisfy `TIMEOUT_CYCLES` < 2^`TIMEOUT_W`.

Ports:
- `clk_main_a0`  in  1  sole clock.
- `rst_main_n_sync`  in  1  synchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in/out  1/1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  write strobes.
- `rsp_valid` / `rsp_ready`  out/in  1/1  response handshake.
- `rsp_write`  out  1  echoes the command type.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_resp`  out  2  BRESP/RRESP from the target, or 2'b10 on timeout.
- `rsp_timeout`  out  1  response was produced by the watchdog.
- `m_axi_awaddr` (out 32), `m_axi_awvalid` (out 1), `m_axi_awready` (in 1) — AXI-L write address channel.
- `m_axi_wdata` (out 32), `m_axi_wstrb` (out 4), `m_axi_wvalid` (out 1), `m_axi_wready` (in 1) — write data channel.
- `m_axi_bresp` (in 2), `m_axi_bvalid` (in 1), `m_axi_bready` (out 1) — write response channel.
- `m_axi_araddr` (out 32), `m_axi_arvalid` (out 1), `m_axi_arready` (in 1) — read address channel.
- `m_axi_rdata` (in 32), `m_axi_rresp` (in 2), `m_axi_rvalid` (in 1), `m_axi_rready` (out 1) — read data channel.
- `wr_count`, `rd_count`  out  32  completed transactions; wrap modulo 2^32.

## Operation
- States:
  - IDLE → WR_REQ on an accepted write command.
  - IDLE → RD_REQ on an accepted read command.
  - WR_REQ → WR_RESP once both AW and W have handshaken.
  - RD_REQ → RD_RESP on AR handshake.
  - WR_RESP / RD_RESP → RSP on the B / R handshake.
  - RSP → IDLE on `rsp_valid && rsp_ready`.
- `cmd_ready` = (state == IDLE) && !drain. Command fields are registered on acceptance.
- WR_REQ raises `awvalid` and `wvalid` together. Each drops independently the cycle after its own handshake. AW and W may complete in either order or in the same cycle.
- Once a valid is asserted, it and its payload stay stable until the handshake (AXI rule).
- `bready` = (state == WR_RESP); `rready` = (state == RD_RESP).
- RSP holds `rsp_*` stable until accepted.
- `wr_count` / `rd_count` increment on the B / R handshake, not on the response handshake.
- All outputs reset to 0, the state resets to IDLE, and `drain` resets to 0. Reset mid-transaction abandons it; valids drop immediately.

## Timing
- Command accepted at cycle T → `awvalid`/`wvalid` (or `arvalid`) high at T+1.
- B or R handshake at cycle U → `rsp_valid` high at U+1.
- Zero-wait target: write command at T produces `rsp_valid` at T+3. The next command can be accepted the cycle after the response handshake.
- `rsp_valid` asserted with `rsp_ready` already high → handshake in that same cycle.

## Configuration
- `CL_OCL_AXIL_MASTER_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WR_RESP/RD_RESP and resets to 0 on entry.
  - When the count reaches `TIMEOUT_CYCLES`-1 without a handshake, the block enters RSP with `rsp_resp` = 2'b10, `rsp_timeout` = 1, `rsp_rdata` = 0, and the counters unchanged.
  - It also sets `drain`. While `drain` is set, `bready` (for a timed-out write) or `rready` (for a timed-out read) stays high. The late beat is discarded and clears `drain`, and `cmd_ready` stays low until then.
  - No timeout applies in WR_REQ/RD_REQ, since valids may not be withdrawn.
- Not defined: no watchdog, no drain logic; `rsp_timeout` is tied to 0; the block waits indefinitely.

## Structure
- Package `cl_ocl_axil_master_pkg` holds:
  - the state enum;
  - response-code constants `AXIL_RESP_OKAY`=2'b00 and `AXIL_RESP_SLVERR`=2'b10;
  - a packed `axil_cmd_t` struct {write, addr, wdata, wstrb}.
- One sub-module, `cl_axil_watchdog`: load/enable/expire counter, instantiated only under the macro.

## Test plan
- Write addr 0x500, data 0xDEAD_BEEF, wstrb 0xF to a zero-wait target → AW/W at T+1, `rsp_valid` at T+3, `rsp_resp`=0, `wr_count`=1; target register holds 0xDEAD_BEEF.
- Read addr 0x500 → `rsp_rdata`=0xDEAD_BEEF, `rsp_write`=0, `rd_count`=1.
- Target accepts W 3 cycles before AW, then delays B by 5 cycles → `wvalid` drops after the W handshake, `awvalid` stays stable until accepted, one response with `rsp_resp`=0.
- Target returns RRESP=2'b10; hold `rsp_ready`=0 for 4 cycles → `rsp_*` stays stable throughout and `cmd_ready`=0 until the response handshake.
- With the macro defined and `TIMEOUT_CYCLES`=8, the target withholds B, then asserts it 20 cycles later → `rsp_timeout`=1 and `rsp_resp`=2'b10 after 8 cycles in WR_RESP; the late B is absorbed; `cmd_ready` returns the cycle after; `wr_count` unchanged.
- Assert reset while in RD_REQ with `arvalid`=1 → next cycle all outputs are 0 and `cmd_ready`=0; after reset release, `cmd_ready`=1 and a new read completes normally.

Source files
------------

// File: rtl/cl_ocl_axil_master_pkg.sv
// Shared types and constants for the cl_ocl_axil_master AXI4-Lite initiator.
package cl_ocl_axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_RSP
    } state_t;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } axil_cmd_t;

endpackage

// File: rtl/cl_ocl_axil_master_if.sv
// Command/response ports and AXI4-Lite master channels of cl_ocl_axil_master.
interface cl_ocl_axil_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    logic [31:0] wr_count;
    logic [31:0] rd_count;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
        input  rsp_ready,
        output m_axi_awaddr, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready,
        output wr_count, rd_count
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
        output rsp_ready,
        input  m_axi_awaddr, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready,
        input  wr_count, rd_count
    );
endinterface

// File: rtl/cl_axil_watchdog.sv
// Load/enable/expire cycle counter bounding the B/R wait phase of cl_ocl_axil_master.
// Instantiated only when CL_OCL_AXIL_MASTER_TIMEOUT_EN is defined.
module cl_axil_watchdog #(
    parameter int CYCLES = 1024,
    parameter int W      = 16
) (
    input  logic clk_main_a0,
    input  logic rst_main_n_sync,
    input  logic load,
    input  logic en,
    output logic expire
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n_sync) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (en && !expire) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign expire = en && (count_reg == W'(CYCLES - 1));
endmodule

// File: rtl/cl_ocl_axil_master.sv
// Single-outstanding AXI4-Lite initiator: command port -> one AXI-L beat -> response port.
// Optional B/R watchdog with late-beat drain when CL_OCL_AXIL_MASTER_TIMEOUT_EN is defined.
module cl_ocl_axil_master
    import cl_ocl_axil_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  logic                 clk_main_a0,
    input  logic                 rst_main_n_sync,
    cl_ocl_axil_master_if.master bus
);
    state_t      state_reg, state_next;
    axil_cmd_t   cmd_reg;
    logic        aw_done_reg, w_done_reg;
    logic [31:0] rsp_rdata_reg;
    logic [1:0]  rsp_resp_reg;
    logic        rsp_timeout_reg;
    logic [31:0] wr_count_reg, rd_count_reg;
    logic        drain_reg;

    logic cmd_ready_c, aw_valid_c, w_valid_c;
    logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic wait_resp, timeout_fire;

    // Gated by reset so the port reads 0 while reset is held, not just after it.
    assign cmd_ready_c = rst_main_n_sync && (state_reg == ST_IDLE) && !drain_reg;
    assign aw_valid_c  = (state_reg == ST_WR_REQ) && !aw_done_reg;
    assign w_valid_c   = (state_reg == ST_WR_REQ) && !w_done_reg;
    assign cmd_hs      = bus.cmd_valid && cmd_ready_c;
    assign aw_hs       = aw_valid_c && bus.m_axi_awready;
    assign w_hs        = w_valid_c && bus.m_axi_wready;
    assign ar_hs       = (state_reg == ST_RD_REQ) && bus.m_axi_arready;
    assign b_hs        = (state_reg == ST_WR_RESP) && bus.m_axi_bvalid;
    assign r_hs        = (state_reg == ST_RD_RESP) && bus.m_axi_rvalid;
    assign wait_resp   = (state_reg == ST_WR_RESP) || (state_reg == ST_RD_RESP);

`ifdef CL_OCL_AXIL_MASTER_TIMEOUT_EN
    logic wd_expire;

    cl_axil_watchdog #(
        .CYCLES (TIMEOUT_CYCLES),
        .W      (TIMEOUT_W)
    ) u_watchdog (
        .clk_main_a0     (clk_main_a0),
        .rst_main_n_sync (rst_main_n_sync),
        .load            (!wait_resp),
        .en              (wait_resp),
        .expire          (wd_expire)
    );

    // A beat arriving on the expiry cycle still wins over the timeout.
    assign timeout_fire = wd_expire && !b_hs && !r_hs;

    // Keeps bready/rready up after a timeout until the late beat is swallowed.
    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n_sync) begin
            drain_reg <= 1'b0;
        end else if (timeout_fire) begin
            drain_reg <= 1'b1;
        end else if (drain_reg && (cmd_reg.write ? bus.m_axi_bvalid : bus.m_axi_rvalid)) begin
            drain_reg <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg   = ^{TIMEOUT_CYCLES, TIMEOUT_W};
    assign timeout_fire = 1'b0;
    assign drain_reg    = 1'b0;
`endif

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n_sync) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (cmd_hs) state_next = bus.cmd_write ? ST_WR_REQ : ST_RD_REQ;
            ST_WR_REQ:  if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) state_next = ST_WR_RESP;
            ST_WR_RESP: if (b_hs || timeout_fire) state_next = ST_RSP;
            ST_RD_REQ:  if (ar_hs) state_next = ST_RD_RESP;
            ST_RD_RESP: if (r_hs || timeout_fire) state_next = ST_RSP;
            ST_RSP:     if (bus.rsp_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready     = cmd_ready_c;
        bus.m_axi_awvalid = aw_valid_c;
        bus.m_axi_awaddr  = cmd_reg.addr;
        bus.m_axi_wvalid  = w_valid_c;
        bus.m_axi_wdata   = cmd_reg.wdata;
        bus.m_axi_wstrb   = cmd_reg.wstrb;
        bus.m_axi_bready  = (state_reg == ST_WR_RESP) || (drain_reg && cmd_reg.write);
        bus.m_axi_arvalid = (state_reg == ST_RD_REQ);
        bus.m_axi_araddr  = cmd_reg.addr;
        bus.m_axi_rready  = (state_reg == ST_RD_RESP) || (drain_reg && !cmd_reg.write);
        bus.rsp_valid     = (state_reg == ST_RSP);
        bus.rsp_write     = cmd_reg.write;
        bus.rsp_rdata     = rsp_rdata_reg;
        bus.rsp_resp      = rsp_resp_reg;
        bus.rsp_timeout   = rsp_timeout_reg;
        bus.wr_count      = wr_count_reg;
        bus.rd_count      = rd_count_reg;
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n_sync) begin
            cmd_reg         <= '0;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= AXIL_RESP_OKAY;
            rsp_timeout_reg <= 1'b0;
            wr_count_reg    <= '0;
            rd_count_reg    <= '0;
        end else begin
            if (cmd_hs) begin
                cmd_reg     <= '{write: bus.cmd_write, addr: bus.cmd_addr,
                                 wdata: bus.cmd_wdata, wstrb: bus.cmd_wstrb};
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else if (state_reg == ST_WR_REQ) begin
                if (aw_hs) aw_done_reg <= 1'b1;
                if (w_hs)  w_done_reg  <= 1'b1;
            end
            if (b_hs) begin
                rsp_rdata_reg   <= '0;
                rsp_resp_reg    <= bus.m_axi_bresp;
                rsp_timeout_reg <= 1'b0;
                wr_count_reg    <= wr_count_reg + 32'd1;
            end else if (r_hs) begin
                rsp_rdata_reg   <= bus.m_axi_rdata;
                rsp_resp_reg    <= bus.m_axi_rresp;
                rsp_timeout_reg <= 1'b0;
                rd_count_reg    <= rd_count_reg + 32'd1;
            end else if (timeout_fire) begin
                rsp_rdata_reg   <= '0;
                rsp_resp_reg    <= AXIL_RESP_SLVERR;
                rsp_timeout_reg <= 1'b1;
            end
        end
    end
endmodule
